// File: rtl/ravenoc_pkg.sv
// Shared NoC types: flit geometry, flit type encoding, head flit overlay and
// the link transmitter state encoding.
package ravenoc_pkg;

  localparam int NumVirtChn = 2;
  localparam int FlitWidth  = 34;
  localparam int VcWidth    = 1;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  // Head flit layout; the type field sits in the same MSBs for every flit type
  typedef struct packed {
    flit_type_t            type_f;
    logic [1:0]            x_dest;
    logic [1:0]            y_dest;
    logic [7:0]            pkt_size;
    logic [FlitWidth-15:0] rsvd;
  } s_flit_head_data_t;

  typedef enum logic {
    TX_IDLE   = 1'b0,
    TX_LOCKED = 1'b1
  } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester found searching upward
// from ptr with wrap-around, returning both a one-hot grant and its index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    logic [IDX_W-1:0] cidx;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    cidx  = '0;
    for (int i = 0; i < N; i++) begin
      // explicit compare keeps the wrap correct for non power-of-two N
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      cidx = IDX_W'(c);
      if (!any && req[cidx]) begin
        any         = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/vc_flit_tx.sv
// Transmit end of the flit link: packet-atomic round-robin over the VC
// sources into a single registered output slot with per-VC downstream ready.
module vc_flit_tx
  import ravenoc_pkg::*;
#(
  parameter int NUM_VC     = NumVirtChn,
  parameter int FLIT_WIDTH = FlitWidth,
  parameter int VC_WIDTH   = VcWidth
) (
  input  logic                             clk,
  input  logic                             arst_n,
  input  logic [NUM_VC-1:0][FLIT_WIDTH-1:0] fdata_i,
  input  logic [NUM_VC-1:0]                valid_i,
  output logic [NUM_VC-1:0]                ready_o,
  output logic [FLIT_WIDTH-1:0]            fdata_o,
  output logic [VC_WIDTH-1:0]              vc_id_o,
  output logic                             valid_o,
  input  logic [NUM_VC-1:0]                ready_i,
  output logic                             busy_o,
  output logic                             error_o
);

  function automatic flit_type_t flit_type(input logic [FLIT_WIDTH-1:0] f);
    s_flit_head_data_t h;
    h = f;
    return h.type_f;
  endfunction

  tx_state_t               state, state_nxt;
  logic [VC_WIDTH-1:0]     lock_vc, lock_vc_nxt;
  logic [VC_WIDTH-1:0]     rr_ptr, rr_ptr_nxt;
  logic                    slot_free;
  logic [NUM_VC-1:0]       head_req, stray_req, grant, rdy;
  logic [VC_WIDTH-1:0]     gnt_idx, stray_idx, load_vc;
  logic                    gnt_any, stray_any, load, err;
  logic [FLIT_WIDTH-1:0]   load_data;
  s_flit_head_data_t       gnt_hdr, lock_hdr;

  assign slot_free = ~valid_o | ready_i[vc_id_o];
  assign gnt_hdr   = fdata_i[gnt_idx];
  assign lock_hdr  = fdata_i[lock_vc];

  always_comb begin
    head_req  = '0;
    stray_req = '0;
    stray_any = 1'b0;
    stray_idx = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      head_req[v]  = valid_i[v] && (flit_type(fdata_i[v]) == HEAD_FLIT);
      stray_req[v] = valid_i[v] && (flit_type(fdata_i[v]) == BODY_FLIT ||
                                    flit_type(fdata_i[v]) == TAIL_FLIT);
    end
    // descending scan so the lowest stray VC wins
    for (int v = NUM_VC - 1; v >= 0; v--) begin
      if (stray_req[v]) begin
        stray_any = 1'b1;
        stray_idx = VC_WIDTH'(v);
      end
    end
  end

  rr_arbiter #(
    .N     (NUM_VC),
    .IDX_W (VC_WIDTH)
  ) u_rr_arbiter (
    .req   (head_req),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    state_nxt   = state;
    lock_vc_nxt = lock_vc;
    rr_ptr_nxt  = rr_ptr;
    rdy         = '0;
    err         = 1'b0;
    load        = 1'b0;
    load_vc     = gnt_idx;
    load_data   = fdata_i[gnt_idx];
    case (state)
      TX_IDLE: begin
        if (gnt_any) begin
          if (slot_free) begin
            rdy        = grant;
            load       = 1'b1;
            rr_ptr_nxt = (gnt_idx == VC_WIDTH'(NUM_VC - 1)) ? '0 : gnt_idx + 1'b1;
            if (gnt_hdr.pkt_size != '0) begin
              state_nxt   = TX_LOCKED;
              lock_vc_nxt = gnt_idx;
            end
          end
        end else if (stray_any) begin
          // orphan body/tail: swallow it so the source cannot stall the link
          rdy[stray_idx] = 1'b1;
          err            = 1'b1;
        end
      end
      TX_LOCKED: begin
        load_vc   = lock_vc;
        load_data = fdata_i[lock_vc];
        if (valid_i[lock_vc]) begin
          if (lock_hdr.type_f == HEAD_FLIT) begin
            err = 1'b1;
          end else if (slot_free) begin
            rdy[lock_vc] = 1'b1;
            load         = 1'b1;
            if (lock_hdr.type_f == TAIL_FLIT) state_nxt = TX_IDLE;
          end
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  assign ready_o = arst_n ? rdy : '0;
  assign error_o = arst_n & err;
  assign busy_o  = (state == TX_LOCKED);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= TX_IDLE;
      lock_vc <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nxt;
      lock_vc <= lock_vc_nxt;
      rr_ptr  <= rr_ptr_nxt;
    end
  end

  // output slot: load and drain in the same cycle keeps 1 flit/cycle
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_o <= 1'b0;
      fdata_o <= '0;
      vc_id_o <= '0;
    end else if (load) begin
      valid_o <= 1'b1;
      fdata_o <= load_data;
      vc_id_o <= load_vc;
    end else if (slot_free) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vc_flit_tx.sv
// Self-checking bench for vc_flit_tx: per-cycle reference model plus directed
// packet scenarios with literal expected link traffic.
module tb_vc_flit_tx;
  import ravenoc_pkg::*;

  localparam int NV = NumVirtChn;
  localparam int FW = FlitWidth;
  localparam int VW = VcWidth;

  logic                   clk = 1'b0;
  logic                   arst_n = 1'b0;
  logic [NV-1:0][FW-1:0]  fdata_i;
  logic [NV-1:0]          valid_i;
  logic [NV-1:0]          ready_o;
  logic [FW-1:0]          fdata_o;
  logic [VW-1:0]          vc_id_o;
  logic                   valid_o;
  logic [NV-1:0]          ready_i;
  logic                   busy_o;
  logic                   error_o;

  always #5 clk = ~clk;

  vc_flit_tx #(.NUM_VC(NV), .FLIT_WIDTH(FW), .VC_WIDTH(VW)) dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .fdata_i (fdata_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .fdata_o (fdata_o),
    .vc_id_o (vc_id_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .error_o (error_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  int err_cnt = 0;

  logic [FW-1:0] q0[$];
  logic [FW-1:0] q1[$];
  logic [FW:0]   lg[$];
  logic [FW:0]   e_lg[$];
  logic [NV-1:0] st_rdy;
  logic          st_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] sz,
                                       input logic [19:0] p);
    return {t, 4'b0000, sz, p};
  endfunction

  function automatic logic [1:0] ftype(input logic [FW-1:0] f);
    return f[FW-1:FW-2];
  endfunction

  function automatic logic [7:0] fsize(input logic [FW-1:0] f);
    return f[FW-7:FW-14];
  endfunction

  function automatic bit vld(input int v);
    return valid_i[v[VW-1:0]];
  endfunction

  function automatic logic [FW-1:0] fd(input int v);
    return fdata_i[v[VW-1:0]];
  endfunction

  // Reference model: link-level behaviour stated as packet rules
  bit            m_lock;
  int            m_lockvc, m_ptr, m_vc;
  bit            m_vld;
  logic [FW-1:0] m_data;

  always @(negedge clk) begin : model
    logic [NV-1:0] e_rdy;
    bit            e_err, free, ld;
    int            g, s, c, ld_vc;
    logic [FW-1:0] ld_d;
    if (!arst_n) begin
      m_lock = 0; m_lockvc = 0; m_ptr = 0; m_vld = 0; m_vc = 0; m_data = '0;
      chk("rst_ready_o", 64'(ready_o), 64'd0);
      chk("rst_valid_o", 64'(valid_o), 64'd0);
      chk("rst_busy_o",  64'(busy_o),  64'd0);
      chk("rst_error_o", 64'(error_o), 64'd0);
    end else begin
      e_rdy = '0; e_err = 0; ld = 0; ld_vc = 0; ld_d = '0;
      free = !m_vld || ready_i[m_vc[VW-1:0]];
      if (!m_lock) begin
        g = -1;
        for (int i = 0; i < NV; i++) begin
          c = (m_ptr + i) % NV;
          if (g < 0 && vld(c) && ftype(fd(c)) == HEAD_FLIT) g = c;
        end
        if (g >= 0) begin
          if (free) begin
            e_rdy[g[VW-1:0]] = 1'b1;
            ld = 1; ld_vc = g; ld_d = fd(g);
          end
        end else begin
          s = -1;
          for (int i = 0; i < NV; i++)
            if (s < 0 && vld(i) && (ftype(fd(i)) == BODY_FLIT || ftype(fd(i)) == TAIL_FLIT))
              s = i;
          if (s >= 0) begin
            e_rdy[s[VW-1:0]] = 1'b1;
            e_err = 1;
          end
        end
      end else if (vld(m_lockvc)) begin
        if (ftype(fd(m_lockvc)) == HEAD_FLIT) e_err = 1;
        else if (free) begin
          e_rdy[m_lockvc[VW-1:0]] = 1'b1;
          ld = 1; ld_vc = m_lockvc; ld_d = fd(m_lockvc);
        end
      end
      chk("ready_o", 64'(ready_o), 64'(e_rdy));
      chk("error_o", 64'(error_o), 64'(e_err));
      chk("busy_o",  64'(busy_o),  64'(m_lock));
      chk("valid_o", 64'(valid_o), 64'(m_vld));
      if (m_vld) begin
        chk("vc_id_o", 64'(vc_id_o), 64'(m_vc));
        chk("fdata_o", 64'(fdata_o), 64'(m_data));
      end
      if (error_o) err_cnt++;
      if (valid_o && ready_i[vc_id_o]) lg.push_back({vc_id_o, fdata_o});
      // state advance for the coming edge
      if (ld) begin
        if (!m_lock) begin
          m_ptr = (ld_vc + 1) % NV;
          if (fsize(ld_d) != 8'd0) begin m_lock = 1; m_lockvc = ld_vc; end
        end else if (ftype(ld_d) == TAIL_FLIT) begin
          m_lock = 0;
        end
        m_vld = 1; m_vc = ld_vc; m_data = ld_d;
      end else if (free) begin
        m_vld = 0;
      end
    end
  end

  task automatic drive();
    valid_i[0] = (q0.size() != 0);
    valid_i[1] = (q1.size() != 0);
    fdata_i[0] = (q0.size() != 0) ? q0[0] : '0;
    fdata_i[1] = (q1.size() != 0) ? q1[0] : '0;
  endtask

  task automatic step(input logic [NV-1:0] rdy);
    logic [NV-1:0] acc;
    ready_i = rdy;
    drive();
    @(negedge clk);
    st_rdy = ready_o;
    st_err = error_o;
    acc = ready_o & valid_i;
    @(posedge clk);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic rst_pulse();
    arst_n = 1'b0;
    q0.delete();
    q1.delete();
    ready_i = '1;
    drive();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    lg.delete();
    e_lg.delete();
    err_cnt = 0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !valid_o) && k < 40) begin
      step('1);
      k++;
    end
    chk("drain_in_budget", 64'(k < 40), 64'd1);
  endtask

  task automatic cmp_log(input string nm);
    chk({nm, "_len"}, 64'(lg.size()), 64'(e_lg.size()));
    for (int i = 0; i < lg.size() && i < e_lg.size(); i++)
      chk(nm, 64'(lg[i]), 64'(e_lg[i]));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    fdata_i = '0;
    valid_i = '0;
    ready_i = '1;

    // 1: single-flit packet on VC1
    rst_pulse();
    q1.push_back(mk(HEAD_FLIT, 8'd0, 20'h000A1));
    step(2'b11);
    chk("t1_ready", 64'(st_rdy), 64'd2);
    chk("t1_valid", 64'(valid_o), 64'd1);
    chk("t1_vc",    64'(vc_id_o), 64'd1);
    chk("t1_data",  64'(fdata_o), 64'(mk(HEAD_FLIT, 8'd0, 20'h000A1)));
    chk("t1_busy",  64'(busy_o),  64'd0);
    drain();
    e_lg.push_back({1'b1, mk(HEAD_FLIT, 8'd0, 20'h000A1)});
    cmp_log("t1_log");

    // 2: VC0 packet holds the link against a waiting VC1 head
    rst_pulse();
    q0.push_back(mk(HEAD_FLIT, 8'd2, 20'h00B00));
    q0.push_back(mk(BODY_FLIT, 8'd0, 20'h00B01));
    q0.push_back(mk(TAIL_FLIT, 8'd0, 20'h00B02));
    q1.push_back(mk(HEAD_FLIT, 8'd0, 20'h00C00));
    step(2'b11);
    chk("t2_ready0", 64'(st_rdy), 64'd1);
    step(2'b11);
    chk("t2_busy", 64'(busy_o), 64'd1);
    drain();
    e_lg.push_back({1'b0, mk(HEAD_FLIT, 8'd2, 20'h00B00)});
    e_lg.push_back({1'b0, mk(BODY_FLIT, 8'd0, 20'h00B01)});
    e_lg.push_back({1'b0, mk(TAIL_FLIT, 8'd0, 20'h00B02)});
    e_lg.push_back({1'b1, mk(HEAD_FLIT, 8'd0, 20'h00C00)});
    cmp_log("t2_log");

    // 3: fairness between two continuous single-flit streams
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(HEAD_FLIT, 8'd0, 20'h00300 + 20'(i)));
      q1.push_back(mk(HEAD_FLIT, 8'd0, 20'h00310 + 20'(i)));
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      e_lg.push_back({1'b0, mk(HEAD_FLIT, 8'd0, 20'h00300 + 20'(i))});
      e_lg.push_back({1'b1, mk(HEAD_FLIT, 8'd0, 20'h00310 + 20'(i))});
    end
    cmp_log("t3_log");

    // 4: downstream stall mid-packet
    rst_pulse();
    q0.push_back(mk(HEAD_FLIT, 8'd3, 20'h00D00));
    q0.push_back(mk(BODY_FLIT, 8'd0, 20'h00D01));
    q0.push_back(mk(BODY_FLIT, 8'd0, 20'h00D02));
    q0.push_back(mk(TAIL_FLIT, 8'd0, 20'h00D03));
    step(2'b11);
    step(2'b11);
    for (int i = 0; i < 3; i++) begin
      step(2'b10);
      chk("t4_stall_ready", 64'(st_rdy), 64'd0);
      chk("t4_hold_vc",     64'(vc_id_o), 64'd0);
      chk("t4_hold_data",   64'(fdata_o), 64'(mk(BODY_FLIT, 8'd0, 20'h00D01)));
    end
    drain();
    e_lg.push_back({1'b0, mk(HEAD_FLIT, 8'd3, 20'h00D00)});
    e_lg.push_back({1'b0, mk(BODY_FLIT, 8'd0, 20'h00D01)});
    e_lg.push_back({1'b0, mk(BODY_FLIT, 8'd0, 20'h00D02)});
    e_lg.push_back({1'b0, mk(TAIL_FLIT, 8'd0, 20'h00D03)});
    cmp_log("t4_log");

    // 5: stray body flit in idle
    rst_pulse();
    q1.push_back(mk(BODY_FLIT, 8'd0, 20'h00E00));
    step(2'b11);
    chk("t5_ready", 64'(st_rdy), 64'd2);
    chk("t5_err",   64'(st_err), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step(2'b11);
      chk("t5_valid", 64'(valid_o), 64'd0);
      chk("t5_err_after", 64'(st_err), 64'd0);
    end
    chk("t5_err_count", 64'(err_cnt), 64'd1);
    cmp_log("t5_log");

    // 6: reset in the middle of a 4-flit packet
    rst_pulse();
    q0.push_back(mk(HEAD_FLIT, 8'd3, 20'h00F00));
    q0.push_back(mk(BODY_FLIT, 8'd0, 20'h00F01));
    q0.push_back(mk(BODY_FLIT, 8'd0, 20'h00F02));
    q0.push_back(mk(TAIL_FLIT, 8'd0, 20'h00F03));
    step(2'b11);
    chk("t6_busy_pre", 64'(busy_o), 64'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(valid_o), 64'd0);
    chk("t6_async_busy",  64'(busy_o),  64'd0);
    chk("t6_async_ready", 64'(ready_o), 64'd0);
    q0.delete();
    q1.delete();
    q1.push_back(mk(HEAD_FLIT, 8'd0, 20'h00F10));
    drive();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    lg.delete();
    e_lg.delete();
    step(2'b11);
    chk("t6_ready_after", 64'(st_rdy), 64'd2);
    drain();
    e_lg.push_back({1'b1, mk(HEAD_FLIT, 8'd0, 20'h00F10)});
    cmp_log("t6_log");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
